// File: rtl/csr_unit_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op encoding,
// and bit positions within mstatus/mie/mip.
package csr_unit_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MISA     = 12'h301;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MHARTID  = 12'hF14;

   typedef enum logic [1:0] {
      CSR_NONE = 2'b00,
      CSR_RW   = 2'b01,
      CSR_RS   = 2'b10,
      CSR_RC   = 2'b11
   } csr_op_e;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MTIE     = 7;
   localparam int MIE_MEIE     = 11;

   localparam logic [31:0] MSTATUS_MPP   = 32'h0000_1800;
   localparam logic [31:0] MSTATUS_WMASK = (32'h1 << MSTATUS_MIE) | (32'h1 << MSTATUS_MPIE);
   localparam logic [31:0] MIE_WMASK     = (32'h1 << MIE_MEIE) | (32'h1 << MIE_MTIE);

   function automatic logic csr_implemented(input logic [11:0] addr);
      case (addr)
         CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
         CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET,
         CSR_MCYCLEH, CSR_MINSTRETH, CSR_MHARTID: csr_implemented = 1'b1;
         default:                                 csr_implemented = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running CNT_WIDTH counter with independently writable 32-bit low half
// and (CNT_WIDTH-32)-bit high half; a write to either half suppresses the increment.
module csr_counter #(
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 inc,
   input  logic                 wr_lo,
   input  logic                 wr_hi,
   input  logic [31:0]          wdata_lo,
   input  logic [CNT_WIDTH-33:0] wdata_hi,
   output logic [CNT_WIDTH-1:0] count
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (wr_lo) begin
         count[31:0] <= wdata_lo;
      end else if (wr_hi) begin
         count[CNT_WIDTH-1:32] <= wdata_hi;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: CSR read/modify/write, trap entry, MRET,
// cycle/instret counters and interrupt-pending generation.
module csr_unit
   import csr_unit_pkg::*;
#(
   parameter logic [31:0] HART_ID     = 32'h0,
   parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
   parameter logic [31:0] MTVEC_RESET = 32'h0,
   parameter int          CNT_WIDTH   = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        csr_valid,
   input  logic [11:0] csr_addr,
   input  logic [1:0]  csr_op,
   input  logic [31:0] csr_wdata,
   input  logic        csr_wr_suppress,
   output logic [31:0] csr_rdata,
   output logic        csr_illegal,
   input  logic        trap_valid,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_tval,
   input  logic        mret_valid,
   input  logic        instr_retire,
   input  logic        irq_ext,
   input  logic        irq_timer,
   output logic [31:0] trap_vector,
   output logic [31:0] mepc_out,
   output logic        irq_pending
);

   logic [31:0] mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip;
   logic [CNT_WIDTH-1:0] mcycle, minstret;
   logic [63:0] cyc_ext, ins_ext;
   csr_op_e     op;
   logic        wr_attempt, wr_en;
   logic [31:0] wval;

   assign mip     = ({31'b0, irq_ext} << MIE_MEIE) | ({31'b0, irq_timer} << MIE_MTIE);
   assign cyc_ext = 64'(mcycle);
   assign ins_ext = 64'(minstret);

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         CSR_MSTATUS:   csr_rdata = mstatus;
         CSR_MISA:      csr_rdata = MISA_VAL;
         CSR_MIE:       csr_rdata = mie;
         CSR_MTVEC:     csr_rdata = mtvec;
         CSR_MSCRATCH:  csr_rdata = mscratch;
         CSR_MEPC:      csr_rdata = mepc;
         CSR_MCAUSE:    csr_rdata = mcause;
         CSR_MTVAL:     csr_rdata = mtval;
         CSR_MIP:       csr_rdata = mip;
         CSR_MCYCLE:    csr_rdata = cyc_ext[31:0];
         CSR_MINSTRET:  csr_rdata = ins_ext[31:0];
         CSR_MCYCLEH:   csr_rdata = cyc_ext[63:32];
         CSR_MINSTRETH: csr_rdata = ins_ext[63:32];
         CSR_MHARTID:   csr_rdata = HART_ID;
         default:       csr_rdata = '0;
      endcase
   end

   // Address space 11xx is read-only: any real write attempt there is illegal.
   always_comb begin
      op          = csr_op_e'(csr_op);
      wr_attempt  = csr_valid && ((op == CSR_RW) ||
                    (((op == CSR_RS) || (op == CSR_RC)) && !csr_wr_suppress));
      csr_illegal = csr_valid && (!csr_implemented(csr_addr) ||
                    ((csr_addr[11:10] == 2'b11) && wr_attempt));
      wr_en       = wr_attempt && !csr_illegal && !trap_valid && !mret_valid;
      case (op)
         CSR_RW:  wval = csr_wdata;
         CSR_RS:  wval = csr_rdata | csr_wdata;
         CSR_RC:  wval = csr_rdata & ~csr_wdata;
         default: wval = csr_rdata;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mstatus  <= MSTATUS_MPP;
         mie      <= '0;
         mtvec    <= MTVEC_RESET & ~32'h2;
         mscratch <= '0;
         mepc     <= '0;
         mcause   <= '0;
         mtval    <= '0;
      end else if (trap_valid) begin
         mepc                  <= trap_pc & ~32'h3;
         mcause                <= trap_cause;
         mtval                 <= trap_tval;
         mstatus[MSTATUS_MPIE] <= mstatus[MSTATUS_MIE];
         mstatus[MSTATUS_MIE]  <= 1'b0;
      end else if (mret_valid) begin
         mstatus[MSTATUS_MIE]  <= mstatus[MSTATUS_MPIE];
         mstatus[MSTATUS_MPIE] <= 1'b1;
      end else if (wr_en) begin
         case (csr_addr)
            CSR_MSTATUS:  mstatus  <= (wval & MSTATUS_WMASK) | MSTATUS_MPP;
            CSR_MIE:      mie      <= wval & MIE_WMASK;
            CSR_MTVEC:    mtvec    <= wval & ~32'h2;
            CSR_MSCRATCH: mscratch <= wval;
            CSR_MEPC:     mepc     <= wval & ~32'h3;
            CSR_MCAUSE:   mcause   <= wval;
            CSR_MTVAL:    mtval    <= wval;
            default: ;
         endcase
      end
   end

   csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
      .clock    (clock),
      .reset    (reset),
      .inc      (1'b1),
      .wr_lo    (wr_en && (csr_addr == CSR_MCYCLE)),
      .wr_hi    (wr_en && (csr_addr == CSR_MCYCLEH)),
      .wdata_lo (wval),
      .wdata_hi (wval[CNT_WIDTH-33:0]),
      .count    (mcycle)
   );

   csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
      .clock    (clock),
      .reset    (reset),
      .inc      (instr_retire),
      .wr_lo    (wr_en && (csr_addr == CSR_MINSTRET)),
      .wr_hi    (wr_en && (csr_addr == CSR_MINSTRETH)),
      .wdata_lo (wval),
      .wdata_hi (wval[CNT_WIDTH-33:0]),
      .count    (minstret)
   );

   // Vectored mode offsets only asynchronous (interrupt) causes.
   assign trap_vector = {mtvec[31:2], 2'b00} +
                        ((mtvec[0] && trap_cause[31]) ? {trap_cause[29:0], 2'b00} : 32'h0);
   assign mepc_out    = mepc;
   assign irq_pending = mstatus[MSTATUS_MIE] && |(mie & mip);

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: expected values are queued when stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_csr_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        csr_valid = 1'b0;
   logic [11:0] csr_addr = '0;
   logic [1:0]  csr_op = '0;
   logic [31:0] csr_wdata = '0;
   logic        csr_wr_suppress = 1'b0;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_pc = '0, trap_cause = '0, trap_tval = '0;
   logic        mret_valid = 1'b0;
   logic        instr_retire = 1'b0;
   logic        irq_ext = 1'b0, irq_timer = 1'b0;
   logic [31:0] trap_vector, mepc_out;
   logic        irq_pending;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] rd;
   logic        ill;

   csr_unit dut (
      .clock(clock), .reset(reset), .csr_valid(csr_valid), .csr_addr(csr_addr),
      .csr_op(csr_op), .csr_wdata(csr_wdata), .csr_wr_suppress(csr_wr_suppress),
      .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .trap_valid(trap_valid),
      .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_tval(trap_tval),
      .mret_valid(mret_valid), .instr_retire(instr_retire), .irq_ext(irq_ext),
      .irq_timer(irq_timer), .trap_vector(trap_vector), .mepc_out(mepc_out),
      .irq_pending(irq_pending)
   );

   always #5 clock = ~clock;

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic peek(input logic [11:0] a, output logic [31:0] r);
      csr_addr = a;
      #1;
      r = csr_rdata;
   endtask

   // One CSR instruction: sample old value / illegal before the edge, commit at the edge.
   task automatic do_csr(input logic [11:0] a, input logic [1:0] o, input logic [31:0] w,
                         input logic s, output logic [31:0] r, output logic il);
      csr_valid = 1'b1; csr_addr = a; csr_op = o; csr_wdata = w; csr_wr_suppress = s;
      #1;
      r  = csr_rdata;
      il = csr_illegal;
      tick();
      csr_valid = 1'b0; csr_op = 2'b00; csr_wdata = '0; csr_wr_suppress = 1'b0;
   endtask

   initial begin
      // Reset values while held in reset
      repeat (2) tick();
      peek(12'h300, rd); push(32'h1800); chk("rst_mstatus", rd);
      reset = 1'b1;
      tick();

      do_csr(12'h300, 2'b00, 0, 0, rd, ill); push(32'h1800); chk("rd_mstatus", rd);
      push(0); chk("rd_mstatus_ill", 32'(ill));
      do_csr(12'h301, 2'b00, 0, 0, rd, ill); push(32'h4000_0100); chk("rd_misa", rd);
      do_csr(12'hF14, 2'b00, 0, 0, rd, ill); push(0); chk("rd_mhartid", rd);
      do_csr(12'h7C0, 2'b00, 0, 0, rd, ill); push(0); chk("unimpl_rdata", rd);
      push(1); chk("unimpl_illegal", 32'(ill));

      // mscratch RW / RS / RC / suppressed RS
      do_csr(12'h340, 2'b01, 32'hA5A5A5A5, 0, rd, ill); push(0); chk("scr_rw_old", rd);
      do_csr(12'h340, 2'b10, 32'h0F, 0, rd, ill); push(32'hA5A5A5A5); chk("scr_rs_old", rd);
      do_csr(12'h340, 2'b11, 32'hA0, 0, rd, ill); push(32'hA5A5A5AF); chk("scr_rc_old", rd);
      do_csr(12'h340, 2'b10, 32'hFF, 1, rd, ill); push(32'hA5A5A50F); chk("scr_final", rd);
      peek(12'h340, rd); push(32'hA5A5A50F); chk("scr_suppressed", rd);

      // Counters: low-half wrap carries into high half; write beats increment
      do_csr(12'hB80, 2'b01, 0, 0, rd, ill);
      do_csr(12'hB00, 2'b01, 32'hFFFF_FFFF, 0, rd, ill);
      tick();
      peek(12'hB00, rd); push(0); chk("mcycle_lo_wrap", rd);
      peek(12'hB80, rd); push(1); chk("mcycle_hi_carry", rd);
      instr_retire = 1'b1;
      do_csr(12'hB02, 2'b01, 32'h5, 0, rd, ill);
      peek(12'hB02, rd); push(5); chk("minstret_wr_override", rd);
      tick();
      instr_retire = 1'b0;
      peek(12'hB02, rd); push(6); chk("minstret_inc", rd);
      tick();
      peek(12'hB02, rd); push(6); chk("minstret_hold", rd);

      // Read-only space
      do_csr(12'hF14, 2'b01, 32'h55, 0, rd, ill); push(1); chk("mhartid_rw_illegal", 32'(ill));
      peek(12'hF14, rd); push(0); chk("mhartid_unchanged", rd);
      do_csr(12'hF14, 2'b10, 32'h0, 1, rd, ill); push(0); chk("mhartid_rs0_legal", 32'(ill));

      // WARL masks
      do_csr(12'h300, 2'b01, 32'hFFFF_FFFF, 0, rd, ill);
      peek(12'h300, rd); push(32'h1888); chk("mstatus_warl", rd);
      do_csr(12'h300, 2'b01, 32'h8, 0, rd, ill);
      do_csr(12'h305, 2'b01, 32'h203, 0, rd, ill);
      peek(12'h305, rd); push(32'h201); chk("mtvec_warl", rd);

      // Trap entry with vectored mtvec
      trap_valid = 1'b1; trap_pc = 32'h103; trap_cause = 32'h8000_0007; trap_tval = 32'hDEAD;
      #1;
      push(32'h21C); chk("trap_vector_vec", trap_vector);
      tick();
      trap_valid = 1'b0;
      peek(12'h341, rd); push(32'h100); chk("trap_mepc", rd);
      push(32'h100); chk("trap_mepc_out", mepc_out);
      peek(12'h342, rd); push(32'h8000_0007); chk("trap_mcause", rd);
      peek(12'h343, rd); push(32'hDEAD); chk("trap_mtval", rd);
      peek(12'h300, rd); push(32'h1880); chk("trap_mstatus", rd);
      trap_cause = 32'h5;
      #1;
      push(32'h200); chk("trap_vector_sync", trap_vector);

      // MRET
      tick();
      mret_valid = 1'b1;
      tick();
      mret_valid = 1'b0;
      peek(12'h300, rd); push(32'h1888); chk("mret_mstatus", rd);

      // Trap + MRET + CSR write in one cycle: only the trap lands
      trap_valid = 1'b1; trap_pc = 32'h200; trap_cause = 32'h2; trap_tval = 32'h0;
      mret_valid = 1'b1;
      do_csr(12'h340, 2'b01, 32'h1234_5678, 0, rd, ill);
      trap_valid = 1'b0; mret_valid = 1'b0;
      peek(12'h340, rd); push(32'hA5A5A50F); chk("prio_mscratch", rd);
      peek(12'h341, rd); push(32'h200); chk("prio_mepc", rd);
      peek(12'h300, rd); push(32'h1880); chk("prio_mstatus", rd);

      // Interrupt pending
      do_csr(12'h304, 2'b01, 32'hFFFF_FFFF, 0, rd, ill);
      peek(12'h304, rd); push(32'h880); chk("mie_warl", rd);
      do_csr(12'h304, 2'b01, 32'h80, 0, rd, ill);
      do_csr(12'h300, 2'b01, 32'h8, 0, rd, ill);
      irq_ext = 1'b1;
      #1;
      push(0); chk("irq_ext_masked", 32'(irq_pending));
      irq_timer = 1'b1;
      #1;
      push(1); chk("irq_timer_pending", 32'(irq_pending));
      peek(12'h344, rd); push(32'h880); chk("mip_read", rd);
      irq_ext = 1'b0; irq_timer = 1'b0;
      tick();

      // Reset asserted in the middle of a write
      csr_valid = 1'b1; csr_addr = 12'h340; csr_op = 2'b01; csr_wdata = 32'hFFFF_0000;
      #2;
      reset = 1'b0;
      #1;
      csr_valid = 1'b0; csr_op = 2'b00;
      peek(12'h340, rd); push(0); chk("rst_mscratch", rd);
      peek(12'h300, rd); push(32'h1800); chk("rst_mstatus2", rd);
      peek(12'h304, rd); push(0); chk("rst_mie", rd);
      peek(12'h305, rd); push(0); chk("rst_mtvec", rd);
      tick();
      peek(12'h341, rd); push(0); chk("rst_mepc", rd);
      peek(12'h342, rd); push(0); chk("rst_mcause", rd);
      peek(12'h343, rd); push(0); chk("rst_mtval", rd);
      peek(12'hB00, rd); push(0); chk("rst_mcycle", rd);
      peek(12'hB02, rd); push(0); chk("rst_minstret", rd);
      tick();
      reset = 1'b1;
      tick();
      peek(12'hB00, rd); push(1); chk("post_rst_mcycle", rd);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
